// File: rtl/mbspfifo.sv
// Multi-bank single-port FIFO; pop-to-valid is RD_LAT+1 cycles, one word per cycle sustained.
// Backpressure: a push on full without a same-cycle pop is dropped and ack stays low.
module mbspfifo_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 1,
  parameter int SRAM   = 0
) (
  input  logic             clk,
  input  logic             re,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;

  generate
    if (SRAM != 0) begin : g_macro
      // Macro pin semantics: a single chip enable, and a write owns the port.
      logic ce;
      assign ce = re | we;
      always_ff @(posedge clk) begin
        if (ce) begin
          if (we) mem[addr] <= wdata;
          else    q1 <= mem[addr];
        end
      end
    end else begin : g_flop
      always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) q1 <= mem[addr];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    q2 <= q1;
  end

  assign rdata = (RD_LAT == 2) ? q2 : q1;
endmodule

module mbspfifo #(
  parameter int WIDTH    = 16,
  parameter int SIZE     = 32,
  parameter int NBANK    = 2,
  parameter int RD_LAT   = 1,
  parameter int AL_FULL  = SIZE - 2,
  parameter int AL_EMPTY = 2,
  parameter int SRAM     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  al_full,
  output logic                  al_empty,
  output logic                  ack,
  output logic [$clog2(SIZE):0] count
);
  localparam int DEPTH = SIZE / NBANK;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = $clog2(NBANK);
  localparam int CW    = $clog2(SIZE) + 1;
  localparam int LAST  = RD_LAT - 1;

  logic [BW-1:0]    rd_bank, wr_bank;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic             kill, ren, wen, corner;
  logic [CW-1:0]    count_nxt;

  logic [NBANK-1:0] hold_v;
  logic [AW-1:0]    hold_addr [NBANK];
  logic [WIDTH-1:0] hold_data [NBANK];

  logic [NBANK-1:0] rd_hit, wr_hit, bk_re, bk_we;
  logic [AW-1:0]    bk_addr  [NBANK];
  logic [WIDTH-1:0] bk_wdata [NBANK];
  logic [WIDTH-1:0] bk_rdata [NBANK];

  logic             pv    [RD_LAT];
  logic             pbyp  [RD_LAT];
  logic [BW-1:0]    pbank [RD_LAT];
  logic [WIDTH-1:0] pdat  [RD_LAT];
  logic [WIDTH-1:0] sel;

  assign full     = (count == CW'(SIZE));
  assign empty    = (count == '0);
  assign al_full  = (count >= CW'(AL_FULL));
  assign al_empty = (count <= CW'(AL_EMPTY));

  assign kill   = rst | flush;
  assign ren    = pop & ~empty & ~kill;
  assign corner = push & pop & empty & ~kill;
  assign wen    = push & (~full | ren) & ~kill & ~corner;
  assign ack    = wen | corner;

  always_comb begin
    count_nxt = count;
    if (wen && !ren)      count_nxt = count + CW'(1);
    else if (ren && !wen) count_nxt = count - CW'(1);
  end

  // Pointers kept as (bank, row) pairs so non-power-of-two SIZE wraps cleanly.
  always_ff @(posedge clk) begin
    if (kill) begin
      rd_bank <= '0;
      rd_addr <= '0;
      wr_bank <= '0;
      wr_addr <= '0;
      count   <= '0;
    end else begin
      count <= count_nxt;
      if (ren) begin
        rd_bank <= rd_bank + BW'(1);
        if (rd_bank == '1) rd_addr <= (rd_addr == AW'(DEPTH-1)) ? '0 : rd_addr + AW'(1);
      end
      if (wen) begin
        wr_bank <= wr_bank + BW'(1);
        if (wr_bank == '1) wr_addr <= (wr_addr == AW'(DEPTH-1)) ? '0 : wr_addr + AW'(1);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      rd_hit[b]   = ren && (rd_bank == BW'(b));
      wr_hit[b]   = wen && (wr_bank == BW'(b));
      bk_re[b]    = rd_hit[b];
      bk_we[b]    = 1'b0;
      bk_addr[b]  = rd_addr;
      bk_wdata[b] = wdata;
      if (!rd_hit[b]) begin
        if (wr_hit[b]) begin
          bk_we[b]   = 1'b1;
          bk_addr[b] = wr_addr;
        end else if (hold_v[b]) begin
          bk_we[b]    = 1'b1;
          bk_addr[b]  = hold_addr[b];
          bk_wdata[b] = hold_data[b];
        end
      end
    end
  end

  // A parked write drains next cycle: both pointers have moved to other banks by then.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (kill) begin
        hold_v[b] <= 1'b0;
      end else if (rd_hit[b] && wr_hit[b]) begin
        hold_v[b]    <= 1'b1;
        hold_addr[b] <= wr_addr;
        hold_data[b] <= wdata;
      end else if (!rd_hit[b] && !wr_hit[b]) begin
        hold_v[b] <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    mbspfifo_bank #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .RD_LAT (RD_LAT),
      .SRAM   (SRAM)
    ) u_bank (
      .clk   (clk),
      .re    (bk_re[b]),
      .we    (bk_we[b]),
      .addr  (bk_addr[b]),
      .wdata (bk_wdata[b]),
      .rdata (bk_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      for (int k = 0; k < RD_LAT; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= ren | corner;
      for (int k = 1; k < RD_LAT; k++) pv[k] <= pv[k-1];
    end
    pbyp[0]  <= corner;
    pbank[0] <= rd_bank;
    pdat[0]  <= wdata;
    for (int k = 1; k < RD_LAT; k++) begin
      pbyp[k]  <= pbyp[k-1];
      pbank[k] <= pbank[k-1];
      pdat[k]  <= pdat[k-1];
    end
  end

  assign sel = pbyp[LAST] ? pdat[LAST] : bk_rdata[pbank[LAST]];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= pv[LAST] & ~flush;
      if (pv[LAST] && !flush) rdata <= sel;
    end
  end

  a_one_hold: assert property (@(posedge clk) disable iff (rst) $onehot0(hold_v));
endmodule

// File: tb/tb_mbspfifo.sv
// Drives two FIFO configurations with shared stimulus and checks each against a queue model.
module tb_mbspfifo;
  localparam int SZ [2] = '{32, 24};
  localparam int LT [2] = '{1, 2};
  localparam int AF [2] = '{30, 22};
  localparam int AE [2] = '{2, 2};

  logic        clk, rst, push, pop, flush;
  logic [15:0] wdata;
  logic [15:0] rdata_o [2];
  logic [5:0]  count_o [2];
  logic        valid_o [2], full_o [2], empty_o [2], al_full_o [2], al_empty_o [2], ack_o [2];

  int          n_cmp = 0, n_bad = 0;
  int          mcnt [2], mhead [2];
  logic [15:0] mbuf [2][32];
  logic        sv [2][4];
  logic [15:0] sd [2][4];
  logic        mv [2];
  logic [15:0] md [2];

  mbspfifo #(.WIDTH(16), .SIZE(32), .NBANK(2), .RD_LAT(1), .AL_FULL(30), .AL_EMPTY(2), .SRAM(0)) u_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .wdata(wdata),
    .rdata(rdata_o[0]), .valid(valid_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .al_full(al_full_o[0]), .al_empty(al_empty_o[0]), .ack(ack_o[0]), .count(count_o[0]));

  mbspfifo #(.WIDTH(16), .SIZE(24), .NBANK(4), .RD_LAT(2), .AL_FULL(22), .AL_EMPTY(2), .SRAM(1)) u_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .wdata(wdata),
    .rdata(rdata_o[1]), .valid(valid_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .al_full(al_full_o[1]), .al_empty(al_empty_o[1]), .ack(ack_o[1]), .count(count_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, compare against the model, then advance the model across the edge.
  task automatic cyc(input logic p, input logic q, input logic f, input logic r, input logic [15:0] d);
    logic kl, emp, ful, rn, cr, wn;
    logic [15:0] nd;
    @(negedge clk);
    push = p; pop = q; flush = f; rst = r; wdata = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      emp = (mcnt[i] == 0);
      ful = (mcnt[i] == SZ[i]);
      kl  = f | r;
      rn  = q & ~emp & ~kl;
      cr  = p & q & emp & ~kl;
      wn  = p & (~ful | rn) & ~kl & ~cr;
      check($sformatf("ack%0d", i), ack_o[i], wn | cr);
      check($sformatf("count%0d", i), count_o[i], mcnt[i]);
      check($sformatf("full%0d", i), full_o[i], ful);
      check($sformatf("empty%0d", i), empty_o[i], emp);
      check($sformatf("al_full%0d", i), al_full_o[i], mcnt[i] >= AF[i]);
      check($sformatf("al_empty%0d", i), al_empty_o[i], mcnt[i] <= AE[i]);
      check($sformatf("valid%0d", i), valid_o[i], mv[i]);
      if (mv[i]) check($sformatf("rdata%0d", i), rdata_o[i], md[i]);
      nd = cr ? d : mbuf[i][mhead[i]];
      if (wn) mbuf[i][(mhead[i] + mcnt[i]) % SZ[i]] = d;
      if (rn) mhead[i] = (mhead[i] + 1) % SZ[i];
      mcnt[i] = mcnt[i] + int'(wn) - int'(rn);
      mv[i] = sv[i][LT[i]-1];
      if (mv[i]) md[i] = sd[i][LT[i]-1];
      for (int k = 3; k > 0; k--) begin
        sv[i][k] = sv[i][k-1];
        sd[i][k] = sd[i][k-1];
      end
      sv[i][0] = rn | cr;
      sd[i][0] = nd;
      if (kl) begin
        mcnt[i] = 0; mhead[i] = 0; mv[i] = 1'b0;
        for (int k = 0; k < 4; k++) sv[i][k] = 1'b0;
      end
      if (r) md[i] = 16'h0;
    end
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mhead[i] = 0; mv[i] = 1'b0; md[i] = 16'h0;
      for (int k = 0; k < 4; k++) begin sv[i][k] = 1'b0; sd[i][k] = 16'h0; end
    end
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; wdata = 16'h0;
    repeat (3) @(posedge clk);
    cyc(0, 0, 0, 1, 16'h0);
    #2;
    check("rst_rdata_a", rdata_o[0], 16'h0);
    check("rst_rdata_b", rdata_o[1], 16'h0);
    cyc(0, 0, 0, 0, 16'h0);

    // Feedthrough on an empty FIFO.
    cyc(1, 1, 0, 0, 16'hA5A5);
    #2;
    check("ft_cnt_a", count_o[0], 0);
    check("ft_cnt_b", count_o[1], 0);
    cyc(0, 0, 0, 0, 16'h0);
    #2;
    check("ft_valid_a", valid_o[0], 1);
    check("ft_rdata_a", rdata_o[0], 16'hA5A5);
    check("ft_early_b", valid_o[1], 0);
    cyc(0, 0, 0, 0, 16'h0);
    #2;
    check("ft_valid_b", valid_o[1], 1);
    check("ft_rdata_b", rdata_o[1], 16'hA5A5);
    check("ft_once_a", valid_o[0], 0);
    repeat (2) cyc(0, 0, 0, 0, 16'h0);

    // In-order fill: A reaches 32, B saturates at 24 and drops the rest.
    for (int n = 0; n < 32; n++) cyc(1, 0, 0, 0, 16'(n));
    #2;
    check("fill_cnt_a", count_o[0], 32);
    check("fill_full_a", full_o[0], 1);
    check("fill_cnt_b", count_o[1], 24);
    check("fill_full_b", full_o[1], 1);

    // Full boundary: push+pop accepted, push alone dropped.
    cyc(1, 1, 0, 0, 16'h0100);
    #2;
    check("fpp_cnt_a", count_o[0], 32);
    check("fpp_cnt_b", count_o[1], 24);
    cyc(1, 0, 0, 0, 16'h0200);
    #2;
    check("fpush_ack_a", ack_o[0], 0);
    check("fpush_ack_b", ack_o[1], 0);
    for (int n = 0; n < 33; n++) cyc(0, 1, 0, 0, 16'h0);
    repeat (4) cyc(0, 0, 0, 0, 16'h0);
    #2;
    check("drain_empty_a", empty_o[0], 1);
    check("drain_empty_b", empty_o[1], 1);

    // Bank collisions: occupancy 4 puts read and write on the same bank every cycle.
    for (int n = 0; n < 4; n++) cyc(1, 0, 0, 0, 16'h0300 + 16'(n));
    for (int n = 0; n < 40; n++) cyc(1, 1, 0, 0, 16'h0400 + 16'(n));
    for (int n = 0; n < 6; n++) cyc(0, 1, 0, 0, 16'h0);
    repeat (4) cyc(0, 0, 0, 0, 16'h0);

    // Flush, then reset, with reads in flight.
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 6; n++) cyc(1, 0, 0, 0, 16'h0500 + 16'(n));
      repeat (3) cyc(0, 1, 0, 0, 16'h0);
      cyc(0, 0, pass == 0, pass == 1, 16'h0);
      #2;
      check("kill_cnt_a", count_o[0], 0);
      check("kill_cnt_b", count_o[1], 0);
      check("kill_empty_b", empty_o[1], 1);
      check("kill_valid_b", valid_o[1], 0);
      if (pass == 1) check("rst_rdata_b2", rdata_o[1], 16'h0);
      repeat (3) cyc(0, 0, 0, 0, 16'h0);
      cyc(1, 1, 0, 0, 16'h5A5A + 16'(pass));
      repeat (4) cyc(0, 0, 0, 0, 16'h0);
    end

    // Random traffic in push-heavy, pop-heavy and balanced phases.
    for (int n = 0; n < 300; n++) begin
      logic p, q;
      if (n < 100)      begin p = ($urandom_range(9) < 9); q = ($urandom_range(9) < 5); end
      else if (n < 200) begin p = ($urandom_range(9) < 5); q = ($urandom_range(9) < 9); end
      else              begin p = ($urandom_range(9) < 7); q = ($urandom_range(9) < 7); end
      cyc(p, q, 0, 0, 16'($urandom));
    end
    for (int n = 0; n < 36; n++) cyc(0, 1, 0, 0, 16'h0);
    repeat (4) cyc(0, 0, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
